uart_frame_parser: RTL and testbench

//  Sits directly downstream of the UART byte receiver; consumes its one-cycle RxD_data_ready/RxD_data strobes.

---
 rtl/uart_frame_parser_pkg.sv | 16 +
 rtl/uart_frame_parser_gap_timer.sv | 29 ++
 rtl/uart_frame_parser.sv | 141 ++++++++++++++
 tb/tb_uart_frame_parser.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/uart_frame_parser_pkg.sv
// Shared definitions for the UART frame parser: FSM encoding and default framing constants.
package uart_frame_parser_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LEN     = 3'd1,
    S_PAYLOAD = 3'd2,
    S_CHECK   = 3'd3,
    S_HOLD    = 3'd4
  } state_e;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
  localparam int         MAX_LEN_DEF   = 16;
  localparam int         TIMEOUT_DEF   = 50000;

endpackage

// File: rtl/uart_frame_parser_gap_timer.sv
// Inter-byte gap timer: counts idle cycles while enabled, pulses expired on the cycle the limit is hit.
module frame_gap_timer #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // A clear (strobe) in the expiry cycle suppresses the pulse.
  assign expired = enable && !clear && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clear || !enable || expired) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_frame_parser.sv
// Framed-packet extractor behind the UART receiver: SYNC, length, payload, XOR checksum.
module uart_frame_parser
  import uart_frame_parser_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEF,
  parameter int         MAX_LEN        = MAX_LEN_DEF,
  parameter int         TIMEOUT_CYCLES = TIMEOUT_DEF,
  localparam int        LEN_W          = $clog2(MAX_LEN + 1),
  localparam int        ADDR_W         = $clog2(MAX_LEN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RxD_data_ready,
  input  logic [7:0]        RxD_data,
  output logic              frame_valid,
  output logic [LEN_W-1:0]  frame_len,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data,
  input  logic              frame_ack,
  output logic              err_len,
  output logic              err_checksum,
  output logic              err_timeout,
  output logic              err_overrun
);

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [ADDR_W-1:0]  idx_q, idx_d;
  logic [7:0]         csum_q, csum_d;
  logic               valid_q, valid_d;
  logic [LEN_W-1:0]   flen_q, flen_d;
  logic               elen_q, elen_d, ecsum_q, ecsum_d;
  logic               eto_q, eto_d, eovr_q, eovr_d;
  logic               buf_we, expired, in_frame;
  logic [7:0]         payload_q [MAX_LEN];

  assign in_frame = (state_q == S_LEN) || (state_q == S_PAYLOAD) || (state_q == S_CHECK);

  frame_gap_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_gap (
    .clk     (clk),
    .rst     (rst),
    .clear   (RxD_data_ready),
    .enable  (in_frame),
    .expired (expired)
  );

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    csum_d  = csum_q;
    elen_d  = 1'b0;
    ecsum_d = 1'b0;
    eto_d   = 1'b0;
    eovr_d  = 1'b0;
    buf_we  = 1'b0;
    unique case (state_q)
      S_IDLE: if (RxD_data_ready && RxD_data == SYNC_BYTE) state_d = S_LEN;
      S_LEN: if (RxD_data_ready) begin
        if (RxD_data == 8'd0 || RxD_data > 8'(MAX_LEN)) begin
          elen_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          len_d   = RxD_data[LEN_W-1:0];
          csum_d  = RxD_data;
          idx_d   = '0;
          state_d = S_PAYLOAD;
        end
      end
      S_PAYLOAD: if (RxD_data_ready) begin
        buf_we = 1'b1;
        csum_d = csum_q ^ RxD_data;
        idx_d  = idx_q + ADDR_W'(1);
        if (LEN_W'(idx_q) == len_q - LEN_W'(1)) state_d = S_CHECK;
      end
      S_CHECK: if (RxD_data_ready) begin
        if (RxD_data == csum_q) state_d = S_HOLD;
        else begin
          ecsum_d = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_HOLD: begin
        // Bytes arriving while the buffer is held are dropped, never parsed.
        eovr_d = RxD_data_ready;
        if (frame_ack) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (expired) begin
      eto_d   = 1'b1;
      state_d = S_IDLE;
    end
    valid_d = (state_d == S_HOLD);
    flen_d  = valid_d ? len_d : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      csum_q  <= '0;
      valid_q <= 1'b0;
      flen_q  <= '0;
      elen_q  <= 1'b0;
      ecsum_q <= 1'b0;
      eto_q   <= 1'b0;
      eovr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      csum_q  <= csum_d;
      valid_q <= valid_d;
      flen_q  <= flen_d;
      elen_q  <= elen_d;
      ecsum_q <= ecsum_d;
      eto_q   <= eto_d;
      eovr_q  <= eovr_d;
    end
  end

  // Payload storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (buf_we) payload_q[idx_q] <= RxD_data;
  end

  always_comb begin
    rd_data = 8'h00;
    if (LEN_W'(rd_addr) < flen_q) rd_data = payload_q[rd_addr];
  end

  assign frame_valid  = valid_q;
  assign frame_len    = flen_q;
  assign err_len      = elen_q;
  assign err_checksum = ecsum_q;
  assign err_timeout  = eto_q;
  assign err_overrun  = eovr_q;

endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed bench for uart_frame_parser with a 100-cycle inter-byte timeout.
module tb_uart_frame_parser;

  localparam int LEN_W  = 5;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              RxD_data_ready = 1'b0;
  logic [7:0]        RxD_data = 8'h00;
  logic              frame_valid;
  logic [LEN_W-1:0]  frame_len;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic [7:0]        rd_data;
  logic              frame_ack = 1'b0;
  logic              err_len, err_checksum, err_timeout, err_overrun;

  int checks = 0;
  int failures = 0;
  int n_len = 0, n_csum = 0, n_to = 0, n_ovr = 0;

  uart_frame_parser #(.TIMEOUT_CYCLES(100)) dut (
    .clk            (clk),
    .rst            (rst),
    .RxD_data_ready (RxD_data_ready),
    .RxD_data       (RxD_data),
    .frame_valid    (frame_valid),
    .frame_len      (frame_len),
    .rd_addr        (rd_addr),
    .rd_data        (rd_data),
    .frame_ack      (frame_ack),
    .err_len        (err_len),
    .err_checksum   (err_checksum),
    .err_timeout    (err_timeout),
    .err_overrun    (err_overrun)
  );

  always #5 clk = ~clk;

  // Pulse counters sampled mid-cycle; a pulse wider than one cycle counts twice.
  always @(negedge clk) begin
    if (err_len)      n_len++;
    if (err_checksum) n_csum++;
    if (err_timeout)  n_to++;
    if (err_overrun)  n_ovr++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One strobe, then idle so bytes are spaced 10 cycles apart.
  task automatic tx(input logic [7:0] b);
    @(posedge clk); #1 RxD_data_ready = 1'b1; RxD_data = b;
    @(posedge clk); #1 RxD_data_ready = 1'b0;
    repeat (8) @(posedge clk);
  endtask

  task automatic ack();
    @(posedge clk); #1 frame_ack = 1'b1;
    @(posedge clk); #1 frame_ack = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [ADDR_W-1:0] a, input logic [7:0] exp);
    rd_addr = a; #1;
    chk(tag, {24'h0, rd_data}, {24'h0, exp});
  endtask

  initial begin
    int first_to;
    #12;
    chk("reset_valid", {31'h0, frame_valid}, 32'h0);
    chk("reset_len",   {27'h0, frame_len}, 32'h0);
    chk("reset_errs",  {28'h0, err_len, err_checksum, err_timeout, err_overrun}, 32'h0);
    @(posedge clk); #1 rst = 1'b1;

    // 1: good frame
    tx(8'hA5); tx(8'h03); tx(8'h11); tx(8'h22); tx(8'h33); tx(8'h03);
    chk("t1_valid", {31'h0, frame_valid}, 32'h1);
    chk("t1_len",   {27'h0, frame_len}, 32'd3);
    rd("t1_rd0", 4'd0, 8'h11);
    rd("t1_rd1", 4'd1, 8'h22);
    rd("t1_rd2", 4'd2, 8'h33);
    rd("t1_rd3", 4'd3, 8'h00);
    ack();
    chk("t1_ack_valid", {31'h0, frame_valid}, 32'h0);
    chk("t1_ack_len",   {27'h0, frame_len}, 32'h0);
    rd("t1_rd0_after_ack", 4'd0, 8'h00);

    // 2: bad checksum (02^10^20 = 32), then a good one-byte frame
    tx(8'hA5); tx(8'h02); tx(8'h10); tx(8'h20); tx(8'hFF);
    chk("t2_csum_pulse", n_csum, 32'd1);
    chk("t2_valid", {31'h0, frame_valid}, 32'h0);
    tx(8'hA5); tx(8'h01); tx(8'h7E); tx(8'h7F);
    chk("t2_good_valid", {31'h0, frame_valid}, 32'h1);
    rd("t2_rd0", 4'd0, 8'h7E);
    ack();

    // 3: length bounds; 16 bytes 01..10 XOR to 10, so checksum is 10^10 = 00
    tx(8'hA5); tx(8'h00);
    chk("t3_len0", n_len, 32'd1);
    tx(8'hA5); tx(8'h11);
    chk("t3_len17", n_len, 32'd2);
    tx(8'hA5); tx(8'h10);
    for (int i = 1; i <= 16; i++) tx(8'(i));
    tx(8'h00);
    chk("t3_valid16", {31'h0, frame_valid}, 32'h1);
    chk("t3_len16",   {27'h0, frame_len}, 32'd16);
    rd("t3_rd0",  4'd0,  8'h01);
    rd("t3_rd15", 4'd15, 8'h10);
    ack();

    // 4: timeout 100 cycles after the last strobe
    tx(8'hA5); tx(8'h04);
    @(posedge clk); #1 RxD_data_ready = 1'b1; RxD_data = 8'h01;
    @(posedge clk); #1 RxD_data_ready = 1'b0;
    first_to = 0;
    for (int n = 1; n <= 120; n++) begin
      @(posedge clk); #1;
      if (err_timeout && first_to == 0) first_to = n;
    end
    chk("t4_to_delay", first_to, 32'd100);
    chk("t4_to_pulses", n_to, 32'd1);
    tx(8'hA5); tx(8'h01); tx(8'h7E); tx(8'h7F);
    chk("t4_after_to_valid", {31'h0, frame_valid}, 32'h1);
    ack();
    // gap of 99 cycles survives; 04^01^02^03^04 = 00
    tx(8'hA5); tx(8'h04);
    @(posedge clk); #1 RxD_data_ready = 1'b1; RxD_data = 8'h01;
    @(posedge clk); #1 RxD_data_ready = 1'b0;
    repeat (97) @(posedge clk);
    tx(8'h02); tx(8'h03); tx(8'h04); tx(8'h00);
    chk("t4_gap99_no_to", n_to, 32'd1);
    chk("t4_gap99_valid", {31'h0, frame_valid}, 32'h1);
    chk("t4_gap99_len",   {27'h0, frame_len}, 32'd4);

    // 5: overrun while held, then overrun with ack
    tx(8'h55);
    chk("t5_ovr1", n_ovr, 32'd1);
    chk("t5_still_valid", {31'h0, frame_valid}, 32'h1);
    rd("t5_rd1", 4'd1, 8'h02);
    tx(8'hA5);
    chk("t5_ovr_sync", n_ovr, 32'd2);
    rd("t5_rd0", 4'd0, 8'h01);
    @(posedge clk); #1 RxD_data_ready = 1'b1; RxD_data = 8'h55; frame_ack = 1'b1;
    @(posedge clk); #1 RxD_data_ready = 1'b0; frame_ack = 1'b0;
    chk("t5_ack_valid", {31'h0, frame_valid}, 32'h0);
    repeat (3) @(posedge clk); #1;
    chk("t5_ovr2", n_ovr, 32'd3);
    tx(8'hA5); tx(8'h01); tx(8'h33); tx(8'h32);
    chk("t5_idle_after_ack", {31'h0, frame_valid}, 32'h1);
    ack();

    // 6: reset mid-frame; checksum of 01,42 is 43
    tx(8'hA5); tx(8'h05); tx(8'h01); tx(8'h02);
    #3 rst = 1'b0; #1;
    chk("t6_rst_valid", {31'h0, frame_valid}, 32'h0);
    chk("t6_rst_len",   {27'h0, frame_len}, 32'h0);
    chk("t6_rst_errs",  {28'h0, err_len, err_checksum, err_timeout, err_overrun}, 32'h0);
    repeat (3) @(posedge clk); #1 rst = 1'b1;
    tx(8'h00); tx(8'hFF); tx(8'hA5); tx(8'h01); tx(8'h42); tx(8'h43);
    chk("t6_valid", {31'h0, frame_valid}, 32'h1);
    rd("t6_rd0", 4'd0, 8'h42);
    chk("t6_no_err_len",  n_len,  32'd2);
    chk("t6_no_err_csum", n_csum, 32'd1);
    chk("t6_no_err_to",   n_to,   32'd1);
    chk("t6_no_err_ovr",  n_ovr,  32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
